register_file: RTL
==================

# register_file

General-purpose register file of the single-cycle MIPS datapath. It sits directly upstream of the 32-bit ALU and supplies both ALU operands, `a` from read port 1 and `b` (R-type) from read port 2. It holds 32 × 32-bit registers, with register 0 hardwired to zero. It provides two combinational read ports and one synchronous write port that takes the write-back result (ALU `R` or memory data) at the end of each instruction cycle.

## Interface
- `DATA_WIDTH`, 32: register width; equals ALU operand width.
- `ADDR_WIDTH`, 5: register index width; depth = 2**ADDR_WIDTH = 32.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous and active-high; clears every register.
- `read_reg1` input ADDR_WIDTH: index for port 1 (instruction rs).
- `read_reg2` input ADDR_WIDTH: index for port 2 (instruction rt).
- `write_reg` input ADDR_WIDTH: destination index (rd or rt, selected upstream by RegDst).
- `write_data` input DATA_WIDTH: value to store.
- `reg_write` input 1: write enable (control unit RegWrite).
- `read_data1` output DATA_WIDTH: contents of `read_reg1`; drives ALU `a`.
- `read_data2` output DATA_WIDTH: contents of `read_reg2`; drives ALU `b` path and store data.

## Operation
- Storage: 32 registers, `DATA_WIDTH` bits each.
- Reset:
  - While `rst`=1, all registers are 0, independent of `clk`.
  - Consequently `read_data1` = `read_data2` = 0 for any address.
- Write:
  - On rising `clk` with `rst`=0, `reg_write`=1 and `write_reg`≠0, register[`write_reg`] ← `write_data`.
  - When `reg_write`=0, no register changes.
- Register 0:
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0, including in the cycle of an attempted write.
- Read:
  - Purely combinational: `read_data1` = register[`read_reg1`] and `read_data2` = register[`read_reg2`].
  - No output register and no enable.
- Both ports may address the same register; both return the identical value.
- No internal write-to-read bypass. Reading the index currently being written returns the old value until the rising edge, and the new value after it. This is required for single-cycle correctness, since the instruction reads its sources before its own write-back.
- Undefined or X on `write_data` is stored as-is. No arithmetic or width conversion; widths must match `DATA_WIDTH` exactly.

## Timing
- Write latency: 1 edge. Data presented with `reg_write`=1 before rising edge N is visible on the read ports immediately after edge N (combinational settle only).
- Read latency: 0 cycles, combinational from address and stored state.
- Asynchronous reset:
  - Assertion takes effect without waiting for `clk`.
  - Deassertion is sampled normally; the first write can occur on the first rising edge with `rst`=0.
- Reset wins over a simultaneous write: a rising edge while `rst`=1 leaves all registers 0.
- Reset mid-program: all previously written values are lost and outputs drop to 0 immediately.
- Back-to-back writes to the same index on consecutive edges: the last one wins, and each value is visible for exactly one cycle.
- Writes to different indices on consecutive edges: independent; no interference.

## Test plan
- Reset check: pulse `rst`=1 asynchronously mid-cycle, then sweep `read_reg1` and `read_reg2` over 0..31 → every read = 0x00000000.
- Write/read sweep: for i=1..31 write 0xA5A50000+i with `reg_write`=1, then read all → register i = 0xA5A50000+i on both ports.
- Register 0 protection: write 0xFFFFFFFF to index 0 → `read_data1`(0) = 0 both before and after the edge. Also `reg_write`=0 writing 0x12345678 to index 5 → register 5 unchanged.
- Read-during-write: register 8 = 0x00000011; drive `write_reg`=8, `write_data`=0x00000022, `read_reg1`=8 → `read_data1`=0x11 before the edge and 0x22 after it.
- Reset priority and mid-operation reset:
  - Assert `rst` together with a write of 0xDEADBEEF to register 3 → register 3 = 0.
  - Write 0xCAFEF00D to register 9, then assert `rst` between edges → `read_data2`(9) falls to 0 without a clock edge.
- ALU hookup: registers 1 = 7 and 2 = 5, `read_reg1`=1, `read_reg2`=2, ALU op=subtract → ALU `R` = 2. With op=slt and operands swapped → `R` = 1.

Source files
------------

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_if
// Description : Read/write port bundle between the datapath and the register
//               file: two read address/data pairs and one write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  // Datapath side: presents indices and write-back data, consumes operands
  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2
  );

  // Register file side
  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2
  );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 32 x 32-bit MIPS general-purpose register file. Two
//               combinational read ports, one synchronous write port,
//               register 0 hardwired to zero, asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  wire logic       clk,
  input  wire logic       rst,
  register_file_if.slave  bus
);

  localparam int c_depth = 2 ** ADDR_WIDTH;

  // Entry 0 exists in the array only so that every index is in range; it is
  // cleared by reset, never written, and masked to zero on the read side.
  logic [DATA_WIDTH-1:0] r_regs [0:c_depth-1];

  logic                  w_write_en;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // A write is only committed to a nonzero destination index
  assign w_write_en = bus.reg_write && (bus.write_reg != '0);

  // Register storage: async clear, write-back on the rising edge; reset wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_depth; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_en) begin
      r_regs[bus.write_reg] <= bus.write_data;
    end
  end

  // Combinational read ports with no write bypass; index 0 always reads zero
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (bus.read_reg1 != '0) begin
      w_rd1 = r_regs[bus.read_reg1];
    end
    if (bus.read_reg2 != '0) begin
      w_rd2 = r_regs[bus.read_reg2];
    end
  end

  assign bus.read_data1 = w_rd1;
  assign bus.read_data2 = w_rd2;

endmodule
`default_nettype wire
